fetch_latch: RTL and testbench

//  Instruction-fetch stage sitting between program_counter and decode. Issues the

---
 rtl/fetch_latch.sv | 138 +++++++++++++
 tb/tb_fetch_latch.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_latch.sv
// fetch_latch: instruction-fetch stage between program_counter and decode.
// Issues the imem read for the current PC and gates pc_en on ihit/stall/flush.
// It registers the fetched word and its PC/PC+4 into the IF/ID latch.
// It parks a word that returns during a decode stall in a one-entry hold buffer.
module fetch_latch #(
   parameter logic [31:0] NOP_WORD = 32'h00000000,
   parameter int          CNT_W    = 16
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic [31:0]      pc_addr,
   input  logic [31:0]      pc_plus_4,
   output logic             pc_en,
   output logic             imemREN,
   output logic [31:0]      imemaddr,
   input  logic             ihit,
   input  logic [31:0]      imemload,
   input  logic             stall,
   input  logic             flush,
   input  logic             halt,
   output logic             ifid_valid,
   output logic [31:0]      ifid_instr,
   output logic [31:0]      ifid_pc,
   output logic [31:0]      ifid_pc_plus_4,
   output logic [CNT_W-1:0] wait_cnt
);

   localparam logic [1:0] FETCH  = 2'd0;
   localparam logic [1:0] HOLD   = 2'd1;
   localparam logic [1:0] HALTED = 2'd2;

   logic [1:0]  state;
   logic [31:0] hold_instr;
   logic [31:0] hold_pc;
   logic [31:0] hold_pc_plus_4;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (&v) return v;
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   assign imemaddr = pc_addr;

   // Read request and PC enable; both forced low while nRST is asserted.
   always_comb begin
      imemREN = 1'b0;
      pc_en   = 1'b0;
      if (nRST) begin
         case (state)
            FETCH: begin
               imemREN = 1'b1;
               if (flush)     pc_en = 1'b1;
               else if (halt) pc_en = 1'b0;
               else           pc_en = ihit;
            end
            HOLD:    pc_en = flush;
            default: pc_en = 1'b0;
         endcase
      end
   end

   // Count cycles where a read is outstanding but the cache has not answered.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         wait_cnt <= '0;
      end else if (state == FETCH && !ihit) begin
         wait_cnt <= sat_inc(wait_cnt);
      end
   end

   // State machine, IF/ID latch and hold buffer.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state          <= FETCH;
         ifid_valid     <= 1'b0;
         ifid_instr     <= NOP_WORD;
         ifid_pc        <= '0;
         ifid_pc_plus_4 <= '0;
         hold_instr     <= NOP_WORD;
         hold_pc        <= '0;
         hold_pc_plus_4 <= '0;
      end else begin
         case (state)
            FETCH: begin
               if (flush || halt) begin
                  // Squash: flush wins over halt and keeps fetching.
                  ifid_valid     <= 1'b0;
                  ifid_instr     <= NOP_WORD;
                  ifid_pc        <= '0;
                  ifid_pc_plus_4 <= '0;
                  if (!flush) state <= HALTED;
               end else if (stall) begin
                  // Decode is frozen; park a returning word until it frees up.
                  if (ihit) begin
                     hold_instr     <= imemload;
                     hold_pc        <= pc_addr;
                     hold_pc_plus_4 <= pc_plus_4;
                     state          <= HOLD;
                  end
               end else if (ihit) begin
                  ifid_valid     <= 1'b1;
                  ifid_instr     <= imemload;
                  ifid_pc        <= pc_addr;
                  ifid_pc_plus_4 <= pc_plus_4;
               end else begin
                  ifid_valid <= 1'b0;
               end
            end
            HOLD: begin
               if (flush || halt) begin
                  ifid_valid     <= 1'b0;
                  ifid_instr     <= NOP_WORD;
                  ifid_pc        <= '0;
                  ifid_pc_plus_4 <= '0;
                  hold_instr     <= NOP_WORD;
                  hold_pc        <= '0;
                  hold_pc_plus_4 <= '0;
                  state          <= flush ? FETCH : HALTED;
               end else if (!stall) begin
                  ifid_valid     <= 1'b1;
                  ifid_instr     <= hold_instr;
                  ifid_pc        <= hold_pc;
                  ifid_pc_plus_4 <= hold_pc_plus_4;
                  state          <= FETCH;
               end
            end
            HALTED: begin
               state <= HALTED;
            end
            default: begin
               state <= FETCH;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_latch.sv
// Directed bench for fetch_latch: reset, hit stream, misses, stall hold,
// flush, halt, asynchronous reset and wait counter saturation.
module tb_fetch_latch;

   logic        CLK;
   logic        nRST;
   logic [31:0] pc_addr;
   logic [31:0] pc_plus_4;
   logic        pc_en;
   logic        imemREN;
   logic [31:0] imemaddr;
   logic        ihit;
   logic [31:0] imemload;
   logic        stall;
   logic        flush;
   logic        halt;
   logic        ifid_valid;
   logic [31:0] ifid_instr;
   logic [31:0] ifid_pc;
   logic [31:0] ifid_pc_plus_4;
   logic [15:0] wait_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   fetch_latch #(.NOP_WORD(32'h00000000), .CNT_W(16)) dut (
      .CLK(CLK), .nRST(nRST), .pc_addr(pc_addr), .pc_plus_4(pc_plus_4),
      .pc_en(pc_en), .imemREN(imemREN), .imemaddr(imemaddr), .ihit(ihit),
      .imemload(imemload), .stall(stall), .flush(flush), .halt(halt),
      .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc),
      .ifid_pc_plus_4(ifid_pc_plus_4), .wait_cnt(wait_cnt)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      nRST = 1'b0; pc_addr = 32'h0; pc_plus_4 = 32'h4; ihit = 1'b1;
      imemload = 32'h0; stall = 1'b0; flush = 1'b0; halt = 1'b0;

      // T1 reset: outputs gated even though ihit=1
      #3;
      chk("t1_imemREN", imemREN, 0);
      chk("t1_pc_en", pc_en, 0);
      chk("t1_valid", ifid_valid, 0);
      chk("t1_instr", ifid_instr, 32'h0);
      chk("t1_wait_cnt", wait_cnt, 0);

      // T2 hit stream
      #5;
      pc_addr = 32'h40; pc_plus_4 = 32'h44; imemload = 32'h20080005; ihit = 1'b1;
      nRST = 1'b1;
      #1;
      chk("t2_imemaddr", imemaddr, 32'h40);
      chk("t2_imemREN", imemREN, 1);
      chk("t2_pc_en", pc_en, 1);
      tick();
      chk("t2_instr", ifid_instr, 32'h20080005);
      chk("t2_pc", ifid_pc, 32'h40);
      chk("t2_pc4", ifid_pc_plus_4, 32'h44);
      chk("t2_valid", ifid_valid, 1);
      chk("t2_wait_cnt", wait_cnt, 0);

      // T3 three miss cycles, then hit
      pc_addr = 32'h44; pc_plus_4 = 32'h48; imemload = 32'h11110000; ihit = 1'b0;
      #1;
      chk("t3_pc_en_miss0", pc_en, 0);
      tick();
      chk("t3_valid_bubble", ifid_valid, 0);
      chk("t3_wait_cnt1", wait_cnt, 1);
      chk("t3_pc_en_miss1", pc_en, 0);
      tick();
      chk("t3_wait_cnt2", wait_cnt, 2);
      chk("t3_pc_en_miss2", pc_en, 0);
      tick();
      chk("t3_wait_cnt3", wait_cnt, 3);
      ihit = 1'b1; imemload = 32'h3C010044;
      #1;
      chk("t3_pc_en_hit", pc_en, 1);
      tick();
      chk("t3_instr", ifid_instr, 32'h3C010044);
      chk("t3_pc", ifid_pc, 32'h44);
      chk("t3_valid", ifid_valid, 1);
      chk("t3_wait_cnt_hold", wait_cnt, 3);

      // T4 stall + hit goes to HOLD
      pc_addr = 32'h48; pc_plus_4 = 32'h4C; imemload = 32'hAAAA0001; stall = 1'b1; ihit = 1'b1;
      #1;
      chk("t4_pc_en_accept", pc_en, 1);
      tick();
      chk("t4_imemREN_hold", imemREN, 0);
      chk("t4_pc_en_hold", pc_en, 0);
      chk("t4_instr_frozen", ifid_instr, 32'h3C010044);
      chk("t4_valid_frozen", ifid_valid, 1);
      pc_addr = 32'h4C; pc_plus_4 = 32'h50; imemload = 32'hDEADBEEF;
      tick();
      chk("t4_instr_frozen2", ifid_instr, 32'h3C010044);
      chk("t4_imemREN_hold2", imemREN, 0);
      stall = 1'b0;
      #1;
      chk("t4_pc_en_release", pc_en, 0);
      tick();
      chk("t4_instr_buf", ifid_instr, 32'hAAAA0001);
      chk("t4_pc_buf", ifid_pc, 32'h48);
      chk("t4_pc4_buf", ifid_pc_plus_4, 32'h4C);
      chk("t4_valid_buf", ifid_valid, 1);
      chk("t4_imemREN_back", imemREN, 1);

      // T5 flush in HOLD drops buffer
      stall = 1'b1; ihit = 1'b1; imemload = 32'h55550002;
      tick();
      chk("t5_imemREN_hold", imemREN, 0);
      flush = 1'b1;
      #1;
      chk("t5_pc_en_flush", pc_en, 1);
      tick();
      chk("t5_valid_flush", ifid_valid, 0);
      chk("t5_instr_flush", ifid_instr, 32'h0);
      chk("t5_imemREN_fetch", imemREN, 1);
      flush = 1'b0; stall = 1'b0; ihit = 1'b0;
      tick();
      chk("t5_buf_dropped", ifid_instr, 32'h0);
      chk("t5_valid_bubble", ifid_valid, 0);
      chk("t5_wait_cnt4", wait_cnt, 4);
      // flush + halt together: flush wins
      flush = 1'b1; halt = 1'b1; ihit = 1'b1; imemload = 32'h77770003;
      #1;
      chk("t5_pc_en_fh", pc_en, 1);
      tick();
      chk("t5_imemREN_fh", imemREN, 1);
      chk("t5_valid_fh", ifid_valid, 0);
      flush = 1'b0; halt = 1'b0;
      #1;
      chk("t5_pc_en_after_fh", pc_en, 1);
      tick();
      chk("t5_instr_after_fh", ifid_instr, 32'h77770003);
      chk("t5_valid_after_fh", ifid_valid, 1);

      // T6 halt
      halt = 1'b1; ihit = 1'b1; imemload = 32'h99990004;
      #1;
      chk("t6_pc_en_halt", pc_en, 0);
      tick();
      chk("t6_imemREN", imemREN, 0);
      chk("t6_valid", ifid_valid, 0);
      chk("t6_instr", ifid_instr, 32'h0);
      halt = 1'b0; flush = 1'b1;
      #1;
      chk("t6_pc_en_flush_ign", pc_en, 0);
      tick();
      chk("t6_imemREN_flush_ign", imemREN, 0);
      flush = 1'b0;
      repeat (3) tick();
      chk("t6_imemREN_stay", imemREN, 0);
      chk("t6_pc_en_stay", pc_en, 0);
      chk("t6_valid_stay", ifid_valid, 0);
      chk("t6_wait_cnt_frozen", wait_cnt, 4);
      // asynchronous reset pulse exits HALTED
      @(negedge CLK);
      nRST = 1'b0;
      #1;
      chk("t6_rst_imemREN", imemREN, 0);
      chk("t6_rst_wait_cnt", wait_cnt, 0);
      #1;
      nRST = 1'b1;
      #1;
      chk("t6_fetch_imemREN", imemREN, 1);
      chk("t6_fetch_pc_en", pc_en, 1);

      // async reset while a word is buffered
      stall = 1'b1; ihit = 1'b1; imemload = 32'hBBBB0005;
      tick();
      chk("t6_hold_imemREN", imemREN, 0);
      @(negedge CLK);
      nRST = 1'b0;
      #1;
      nRST = 1'b1; stall = 1'b0; ihit = 1'b0;
      #1;
      chk("t6_rst_hold_imemREN", imemREN, 1);
      tick();
      chk("t6_rst_buf_lost", ifid_instr, 32'h0);
      chk("t6_rst_valid", ifid_valid, 0);

      // wait counter saturation: one miss already counted above
      repeat (65535) tick();
      chk("t6_wait_sat", wait_cnt, 32'hFFFF);
      tick();
      chk("t6_wait_no_wrap", wait_cnt, 32'hFFFF);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
